// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and default widths.
package pc_seq_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int INSTR_BYTES_DEF = 4;
  localparam int CNT_W_DEF       = 32;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DROP,
    OUT
  } fetch_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch controller: drives the external PC register and the imem req/ack handshake, with a one-entry output stage.
// The instruction is valid the cycle after the ack and is held until it is accepted by instr_ready or squashed by a redirect.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              align_err,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              align_err_q, align_err_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
  logic [ADDR_W-1:0] target;

  assign target = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_next       = pc_cur;
    pend_pc_d     = pend_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    align_err_d   = align_err_q | (redirect & (redirect_pc[1:0] != 2'b00));

    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem_ack && !redirect) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_cur;
          pc_next    = pc_cur + ADDR_W'(INSTR_BYTES);
          state_d    = OUT;
        end else if (imem_ack && redirect) begin
          pc_next = target;
        end else if (redirect) begin
          // The request is already on the bus; remember where to go once it retires.
          pend_pc_d = target;
          state_d   = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          pc_next = redirect ? target : pend_pc_q;
          state_d = FETCH;
        end else if (redirect) begin
          pend_pc_d = target;
        end
      end
      OUT: begin
        if (redirect) begin
          pc_next = target;
          state_d = FETCH;
        end else if (instr_ready) begin
          fetch_count_d = fetch_count_q + CNT_W'(1);
          state_d       = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pend_pc_q     <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      align_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      align_err_q   <= align_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr   = pc_cur;
  assign instr_valid = (state_q == OUT);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign align_err   = align_err_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: external PC register, directed table, corner sequences and random traffic vs a flag-based model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_cur, pc_next, imem_addr, imem_rdata, redirect_pc, instr, instr_pc, fetch_count;
  logic        imem_req, imem_ack, redirect, instr_valid, instr_ready, align_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // PC register outside the sequencer, loads every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_cur <= '0;
    else     pc_cur <= pc_next;
  end

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .align_err(align_err), .fetch_count(fetch_count)
  );

  // Reference model: what the fetch path is doing, as plain flags.
  logic        m_boot, m_holding, m_dropping, m_err;
  logic [31:0] m_pc, m_pend, m_instr, m_ipc, m_cnt;

  // Snapshot of DUT outputs taken mid-cycle in each step.
  logic        s_req, s_valid, s_err;
  logic [31:0] s_addr, s_pcn, s_ipc, s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_holding = 1'b0; m_dropping = 1'b0; m_err = 1'b0;
    m_pc = '0; m_pend = '0; m_instr = '0; m_ipc = '0; m_cnt = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc",   instr_pc, 32'd0);
    chk("rst_err",   32'(align_err), 32'd0);
    chk("rst_cnt",   fetch_count, 32'd0);
    chk("rst_pcn",   pc_next, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic a, input logic [31:0] d, input logic r,
                      input logic [31:0] rp, input logic rd);
    logic        e_req, n_boot, n_hold, n_drop, n_err;
    logic [31:0] tgt, e_pcn, n_pend, n_instr, n_ipc, n_cnt;
    imem_ack = a; imem_rdata = d; redirect = r; redirect_pc = rp; instr_ready = rd;
    #1;
    tgt    = rp & 32'hFFFF_FFFC;
    e_req  = !m_boot && !m_holding;
    e_pcn  = m_pc;
    n_boot = 1'b0; n_hold = m_holding; n_drop = m_dropping;
    n_pend = m_pend; n_instr = m_instr; n_ipc = m_ipc; n_cnt = m_cnt;
    n_err  = m_err || (r && rp[1:0] != 2'b00);
    if (m_boot) begin
      // first cycle after reset issues nothing
    end else if (m_holding) begin
      if (r) begin e_pcn = tgt; n_hold = 1'b0; end
      else if (rd) begin n_cnt = m_cnt + 1; n_hold = 1'b0; end
    end else if (m_dropping) begin
      if (a) begin e_pcn = r ? tgt : m_pend; n_drop = 1'b0; end
      else if (r) n_pend = tgt;
    end else begin
      if (a && !r) begin n_instr = d; n_ipc = m_pc; e_pcn = m_pc + 4; n_hold = 1'b1; end
      else if (a) e_pcn = tgt;
      else if (r) begin n_pend = tgt; n_drop = 1'b1; end
    end
    s_req = imem_req; s_addr = imem_addr; s_pcn = pc_next; s_valid = instr_valid;
    s_ipc = instr_pc; s_cnt = fetch_count; s_err = align_err;
    chk("pc_cur", pc_cur, m_pc);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("pc_next", pc_next, e_pcn);
    chk("instr_valid", 32'(instr_valid), 32'(m_holding));
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("align_err", 32'(align_err), 32'(m_err));
    chk("fetch_count", fetch_count, m_cnt);
    @(posedge clk);
    m_boot = n_boot; m_holding = n_hold; m_dropping = n_drop; m_err = n_err;
    m_pc = e_pcn; m_pend = n_pend; m_instr = n_instr; m_ipc = n_ipc; m_cnt = n_cnt;
    @(negedge clk);
  endtask

  typedef struct {
    logic        ack;
    logic        rdy;
    logic [31:0] rdata;
    logic        x_req;
    logic [31:0] x_pcn;
    logic        x_valid;
    logic [31:0] x_ipc;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    // Back-to-back acks with ready high; acks in BOOT/OUT rows must be ignored.
    tbl[0] = '{1'b1, 1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'd0};
    tbl[1] = '{1'b1, 1'b1, 32'hA000_0001, 1'b1, 32'h4, 1'b0, 32'h0, 32'd0};
    tbl[2] = '{1'b1, 1'b1, 32'hA000_0002, 1'b0, 32'h4, 1'b1, 32'h0, 32'd0};
    tbl[3] = '{1'b1, 1'b1, 32'hA000_0003, 1'b1, 32'h8, 1'b0, 32'h0, 32'd1};
    tbl[4] = '{1'b1, 1'b1, 32'hA000_0004, 1'b0, 32'h8, 1'b1, 32'h4, 32'd1};
    tbl[5] = '{1'b1, 1'b1, 32'hA000_0005, 1'b1, 32'hC, 1'b0, 32'h4, 32'd2};
    tbl[6] = '{1'b1, 1'b1, 32'hA000_0006, 1'b0, 32'hC, 1'b1, 32'h8, 32'd2};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].ack, tbl[i].rdata, 1'b0, 32'h0, tbl[i].rdy);
      chk($sformatf("tbl%0d_req", i),   32'(s_req),   32'(tbl[i].x_req));
      chk($sformatf("tbl%0d_pcn", i),   s_pcn,        tbl[i].x_pcn);
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].x_valid));
      chk($sformatf("tbl%0d_ipc", i),   s_ipc,        tbl[i].x_ipc);
      chk($sformatf("tbl%0d_cnt", i),   s_cnt,        tbl[i].x_cnt);
    end
    chk("cnt_after_3", fetch_count, 32'd3);
    chk("instr_last", instr, 32'hA000_0005);

    // Ack delayed three cycles at 0x10.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b1, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("wait_req", 32'(s_req), 32'd1);
      chk("wait_addr", s_addr, 32'h10);
      chk("wait_pcn", s_pcn, 32'h10);
      chk("wait_valid", 32'(s_valid), 32'd0);
    end
    step(1'b1, 32'hDEAD_0010, 1'b0, 32'h0, 1'b0);
    chk("dly_ack_pcn", s_pcn, 32'h14);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("dly_valid", 32'(s_valid), 32'd1);
    chk("dly_ipc", s_ipc, 32'h10);

    // Redirect while waiting at 0x20 -> DROP, late ack discarded.
    step(1'b1, 32'h0, 1'b1, 32'h20, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    chk("drop_pcn0", s_pcn, 32'h20);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("drop_req", 32'(s_req), 32'd1);
      chk("drop_addr", s_addr, 32'h20);
    end
    step(1'b1, 32'hBAD0_0020, 1'b0, 32'h0, 1'b1);
    chk("drop_ack_pcn", s_pcn, 32'h100);
    chk("drop_valid", 32'(s_valid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("post_drop_addr", s_addr, 32'h100);
    chk("post_drop_valid", 32'(s_valid), 32'd0);

    // Squash from OUT holding 0x8 with ready low.
    step(1'b1, 32'h0, 1'b1, 32'h8, 1'b0);
    step(1'b1, 32'h1234_0008, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("hold_valid", 32'(s_valid), 32'd1);
    chk("hold_ipc", s_ipc, 32'h8);
    step(1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    chk("squash_pcn", s_pcn, 32'h40);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("squash_valid", 32'(s_valid), 32'd0);
    chk("squash_addr", s_addr, 32'h40);
    chk("squash_cnt", s_cnt, 32'd1);

    // Misaligned redirect, then PC wrap at the top of the address space.
    step(1'b1, 32'h0, 1'b1, 32'h103, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("mis_addr", s_addr, 32'h100);
    chk("mis_err", 32'(s_err), 32'd1);
    step(1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 32'h5555_AAAA, 1'b0, 32'h0, 1'b1);
    chk("wrap_pcn", s_pcn, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("wrap_ipc", s_ipc, 32'hFFFF_FFFC);
    chk("err_sticky", 32'(s_err), 32'd1);

    // Asynchronous reset in the middle of a DROP.
    step(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_req", 32'(s_req), 32'd1);
    #2;
    do_reset();
    step(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("boot_req", 32'(s_req), 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("boot_fetch_req", 32'(s_req), 32'd1);
    chk("boot_fetch_addr", s_addr, 32'h0);

    // Random traffic against the model, periodically reset to re-arm align_err.
    for (int i = 0; i < 3000; i++) begin
      logic        a, r, rd;
      logic [31:0] rp;
      if (i % 500 == 0) do_reset();
      a  = ($urandom_range(0, 9) < 4);
      r  = ($urandom_range(0, 11) == 0);
      rp = $urandom;
      if ($urandom_range(0, 15) != 0) rp[1:0] = 2'b00;
      rd = ($urandom_range(0, 2) != 0);
      step(a, $urandom, r, rp, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch controller that sequences the PC register and the instruction-memory handshake. It drives the PC register's next-value input every cycle and reads the current PC back. It issues req/ack fetches to instruction memory and presents fetched instructions downstream over a valid/ready handshake. Branch/jump redirects from the execute stage take priority over sequential fetch, and wrong-path instructions are squashed.

Parameters:
ADDR_W, 32, PC / instruction address width
DATA_W, 32, instruction width
INSTR_BYTES, 4, sequential PC increment
CNT_W, 32, width of delivered-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
pc_cur  in  ADDR_W  current PC register output
pc_next  out  ADDR_W  combinational next value for PC register input (PC loads every cycle)
imem_req  out  1  fetch request, held until ack
imem_addr  out  ADDR_W  fetch address, equals pc_cur while imem_req=1
imem_ack  in  1  memory response valid, one cycle
imem_rdata  in  DATA_W  instruction data, valid with imem_ack
redirect  in  1  one-cycle redirect pulse (taken branch/jump)
redirect_pc  in  ADDR_W  redirect target
instr_valid  out  1  instruction available downstream
instr_ready  in  1  downstream accepts
instr  out  DATA_W  registered instruction
instr_pc  out  ADDR_W  address of instr
align_err  out  1  sticky: redirect target had low 2 bits non-zero
fetch_count  out  CNT_W  count of delivered instructions (valid&ready), wraps

Behaviour:
- Reset (async, rst=1): state=BOOT; imem_req=0, instr_valid=0, instr=0, instr_pc=0, align_err=0, fetch_count=0, pend_pc=0. The PC register resets to 0 in parallel. pc_next=pc_cur during reset.
- Default pc_next=pc_cur (hold) unless a rule below overrides it.
- Redirect target used = {redirect_pc[ADDR_W-1:2],2'b00}. If redirect=1 with redirect_pc[1:0]!=0, align_err sets and stays set until reset.
- BOOT: one cycle, no request, then go to FETCH.
- FETCH: imem_req=1, imem_addr=pc_cur.
  - ack & !redirect: instr<=imem_rdata, instr_pc<=pc_cur; pc_next=pc_cur+INSTR_BYTES (mod 2^ADDR_W, wraps 0xFFFFFFFC->0); go to OUT.
  - ack & redirect: discard data; pc_next=target; stay in FETCH (new request next cycle at target).
  - !ack & redirect: pend_pc<=target; go to DROP.
  - !ack & !redirect: stay.
- DROP: imem_req=1, same imem_addr (request is never withdrawn before ack). A further redirect overwrites pend_pc.
  - On ack: discard data; pc_next = redirect ? target : pend_pc; go to FETCH.
- OUT: instr_valid=1, imem_req=0; instr/instr_pc stable.
  - redirect (any instr_ready): squash; instr_valid=0 next cycle; pc_next=target; fetch_count unchanged; go to FETCH.
  - instr_ready & !redirect: fetch_count++; go to FETCH.
  - else hold.
- Throughput: at most one instruction per 2 cycles (FETCH with same-cycle ack, then OUT with ready). Latency from request to instr_valid = ack cycle + 1.
- imem_ack outside FETCH/DROP: ignored.
- Reset mid-fetch: outstanding request abandoned; memory must tolerate a dropped ack.

Decomposition:
- Shared package pc_seq_pkg: state enum {BOOT, FETCH, DROP, OUT}, INSTR_BYTES, ADDR_W/DATA_W defaults.
- No sub-module needed. The incrementer is inline; the PC register stays external and is fed by pc_next.

Test Plan:
- Reset then memory acks every cycle, ready=1 -> instr_pc sequence 0x0, 0x4, 0x8; instr_valid every 2nd cycle; fetch_count=3 after third handshake.
- Ack delayed 3 cycles at PC 0x10 -> imem_req/imem_addr=0x10 held 3 cycles, pc_next=0x10 throughout; instr_valid one cycle after ack.
- Redirect to 0x100 while waiting at 0x20 with no ack -> DROP; ack arrives 2 cycles later, data discarded, next request at 0x100, instr_valid never asserted for 0x20.
- In OUT holding 0x8 with ready=0, redirect to 0x40 -> instr_valid drops, fetch_count unchanged, next imem_addr=0x40.
- Redirect to 0x103 -> fetch at 0x100, align_err=1 and remains 1 until rst.
- Assert rst mid-DROP -> all outputs at reset values immediately; after release BOOT, then fetch at 0x0.
